// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFUN opcodes used by ALU control and the multiply sequencer.
`timescale 1ns/1ps
package alu_pkg;

    localparam int unsigned ALUFUN_W = 4;

    typedef logic [ALUFUN_W-1:0] alufun_t;

    // ARM data-processing opcodes as presented to the shared ALU
    localparam alufun_t ALUFUN_AND = 4'b0000;
    localparam alufun_t ALUFUN_EOR = 4'b0001;
    localparam alufun_t ALUFUN_SUB = 4'b0010;
    localparam alufun_t ALUFUN_RSB = 4'b0011;
    localparam alufun_t ALUFUN_ADD = 4'b0100;
    localparam alufun_t ALUFUN_ADC = 4'b0101;
    localparam alufun_t ALUFUN_SBC = 4'b0110;
    localparam alufun_t ALUFUN_RSC = 4'b0111;
    localparam alufun_t ALUFUN_ORR = 4'b1100;
    localparam alufun_t ALUFUN_MOV = 4'b1101;
    localparam alufun_t ALUFUN_BIC = 4'b1110;
    localparam alufun_t ALUFUN_MVN = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Core/ALU <-> multiply sequencer connection; master is the core side, slave the sequencer.
`timescale 1ns/1ps
interface mul_sequencer_if #(
    parameter int unsigned BUS = 32
);
    logic           start;
    logic           accumulate;
    logic           set_flags;
    logic           cancel;
    logic [BUS-1:0] op_rm;
    logic [BUS-1:0] op_rs;
    logic [BUS-1:0] op_rn;
    logic [BUS-1:0] alu_a;
    logic [BUS-1:0] alu_b;
    logic [3:0]     alu_fun;
    logic [BUS-1:0] alu_result;
    logic           busy;
    logic           done;
    logic [BUS-1:0] result;
    logic           flag_n;
    logic           flag_z;
    logic           flags_valid;

    modport master (
        output start, accumulate, set_flags, cancel, op_rm, op_rs, op_rn, alu_result,
        input  alu_a, alu_b, alu_fun, busy, done, result, flag_n, flag_z, flags_valid
    );

    modport slave (
        input  start, accumulate, set_flags, cancel, op_rm, op_rs, op_rn, alu_result,
        output alu_a, alu_b, alu_fun, busy, done, result, flag_n, flag_z, flags_valid
    );

endinterface

// File: rtl/mul_sequencer.sv
// MUL/MLA sequencer: radix-2 shift-add over the shared ALU, one ADD per cycle,
// terminating once no multiplier bits remain.
`timescale 1ns/1ps
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned BUS     = 32,
    parameter logic [3:0]  ALU_ADD = ALUFUN_ADD
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(BUS);

    mul_state_t     state, state_n;
    logic [BUS-1:0] acc, acc_n;
    logic [BUS-1:0] mcand, mcand_n;
    logic [BUS-1:0] mult, mult_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic           sf_q, sf_n;

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        acc_n   = acc;
        mcand_n = mcand;
        mult_n  = mult;
        cnt_n   = cnt;
        sf_n    = sf_q;
        if (bus.cancel) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_n   = bus.accumulate ? bus.op_rn : '0;
                        mcand_n = bus.op_rm;
                        mult_n  = bus.op_rs;
                        cnt_n   = '0;
                        sf_n    = bus.set_flags;
                        state_n = (bus.op_rs != '0) ? ITER : DONE;
                    end
                end
                ITER: begin
                    acc_n   = bus.alu_result;
                    mcand_n = mcand << 1;
                    mult_n  = mult >> 1;
                    cnt_n   = cnt + CNT_W'(1);
                    if ((mult_n == '0) || (cnt == CNT_W'(BUS - 1))) begin
                        state_n = DONE;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // ALU operands are registered one cycle ahead so they equal acc/mcand while in ITER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            acc             <= '0;
            mcand           <= '0;
            mult            <= '0;
            cnt             <= '0;
            sf_q            <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_fun     <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.flag_n      <= 1'b0;
            bus.flag_z      <= 1'b0;
            bus.flags_valid <= 1'b0;
        end else begin
            state           <= state_n;
            acc             <= acc_n;
            mcand           <= mcand_n;
            mult            <= mult_n;
            cnt             <= cnt_n;
            sf_q            <= sf_n;
            bus.busy        <= (state_n != IDLE);
            bus.done        <= (state_n == DONE);
            bus.flags_valid <= (state_n == DONE) && sf_n;
            if (state_n == ITER) begin
                bus.alu_a   <= acc_n;
                bus.alu_b   <= mult_n[0] ? mcand_n : '0;
                bus.alu_fun <= ALU_ADD;
            end else begin
                bus.alu_a   <= '0;
                bus.alu_b   <= '0;
                bus.alu_fun <= '0;
            end
            if (state_n == DONE) begin
                bus.result <= acc_n;
                bus.flag_n <= acc_n[BUS-1];
                bus.flag_z <= (acc_n == '0);
            end
        end
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle sequencer for ARMv4 MUL/MLA that reuses the shared 32-bit ALU instead of adding a dedicated multiplier.
- Performs radix-2 shift-add, one ALU ADD per cycle, with early termination on the highest set multiplier bit.
- Sits beside the execute stage. While `busy` is high, the core stalls and muxes `alu_a`, `alu_b` and `alu_fun` from this block onto the ALU.

Parameters:
- BUS, 32, datapath width (operands, accumulator, result)
- ALU_ADD, 4'b0100, ALUFUN code driven during iterations (ARM ADD opcode)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; accepted only in IDLE
- accumulate  in  1  1 = MLA (acc init = op_rn), 0 = MUL (acc init = 0); sampled with start
- set_flags  in  1  S bit; sampled with start
- cancel  in  1  pipeline flush; aborts any operation
- op_rm  in  BUS  multiplicand
- op_rs  in  BUS  multiplier
- op_rn  in  BUS  accumulate operand
- alu_a  out  BUS  ALU operand A (accumulator)
- alu_b  out  BUS  ALU operand B (masked shifted multiplicand)
- alu_fun  out  4  ALUFUN code to ALU
- alu_result  in  BUS  ALU sum, combinational from alu_a/alu_b
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- result  out  BUS  product (low BUS bits), held until next accepted start
- flag_n  out  1  result[BUS-1]; valid with flags_valid
- flag_z  out  1  result == 0; valid with flags_valid
- flags_valid  out  1  done & latched set_flags

Behaviour:
- Reset values: all outputs 0, including result, flags and alu_fun. State is IDLE; internal registers acc, mcand, mult and cnt are all 0.
- States: IDLE, ITER, DONE.
- IDLE:
  - On start & !cancel:
    - acc <= accumulate ? op_rn : 0
    - mcand <= op_rm, mult <= op_rs, cnt <= 0
    - latch set_flags
  - Next state is ITER if op_rs != 0, else DONE.
- ITER, each cycle:
  - Drive alu_a = acc, alu_b = mult[0] ? mcand : 0, alu_fun = ALU_ADD.
  - acc <= alu_result; mcand <= mcand << 1; mult <= mult >> 1; cnt <= cnt + 1.
  - If (mult >> 1) == 0 or cnt == BUS-1, go to DONE.
- DONE (one cycle):
  - done = 1; result register <= acc (visible on the result port from the DONE cycle onward); flags computed from acc.
  - flags_valid = latched set_flags.
  - Go to IDLE.
- Outside ITER: alu_a = 0, alu_b = 0, alu_fun = 0.
- Arithmetic: modulo 2^BUS. Carry and overflow from the ALU are ignored. C and V flags are not produced (ARMv4 leaves them unaffected/unpredictable).
- Latency: start accepted at edge 0. With k = index of highest set bit of op_rs plus 1, done is high in cycle k+1; for op_rs = 0, done is in cycle 1. Maximum is BUS+1 cycles.
- Back-to-back: start in the same cycle as done is ignored, because state is not IDLE. The next start is accepted the cycle after done.
- start while busy: ignored; no registers change.
- cancel: from any state, next state is IDLE, no done pulse, and result and flags are not updated. cancel has priority over start in IDLE.
- Async reset mid-operation: immediate return to reset values; no done pulse.

Decomposition:
- Shared package alu_pkg holds:
  - ALUFUN opcode constants (ADD, SUB, MOV, MVN, ...), reused by ALU control and this block.
  - typedef enum logic [1:0] {IDLE, ITER, DONE} mul_state_t.
- No sub-module. One FSM plus the datapath registers in a single module; the ALU remains external and shared.

Test Plan:
- MUL: rm=3, rs=5, accumulate=0, S=1 -> done in cycle 4, result=15, flag_n=0, flag_z=0, flags_valid=1; alu_fun=4'b0100 during ITER only.
- MLA: rm=7, rs=6, rn=10 -> result=52 in cycle 4; with S=0, flags_valid=0.
- rs=0, MLA rn=0x1234 -> no ITER, done in cycle 1, result=0x1234. Then MUL rm=0x10000, rs=0x10000, S=1 -> result=0, flag_z=1.
- rm=rs=0xFFFFFFFF -> 32 iterations, done in cycle 33, result=1. Then rm=0x80000000, rs=1, S=1 -> result=0x80000000, flag_n=1.
- Assert start during ITER with different operands -> ignored, first result correct. Start held high across done -> second op accepted the cycle after done.
- cancel in ITER cycle 2 of rm=9, rs=0xFF -> busy=0 next cycle, no done, result keeps previous value. Repeat with rst_n pulsed low mid-ITER -> all outputs 0 immediately.
